operand_feeder: RTL and testbench

Upstream operand stage for the 8-bit sum datapath. It takes a byte stream on a valid/ready interface and pairs consecutive bytes into operands (a, b). It buffers up to DEPTH pairs in a FIFO and presents the head pair to the downstream sum stage on a second valid/ready interface. Both interfaces apply backpressure, so no data is ever dropped.

---
 rtl/operand_feeder.sv | 138 +++++++++++++
 tb/tb_operand_feeder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_feeder.sv
// operand_feeder: pairs consecutive bytes into (a, b) operands and buffers
// up to DEPTH pairs for the downstream sum stage.
// Optional feature macro: OPERAND_FEEDER_SUM_EN adds out_sum/out_carry,
// computed at push time and stored alongside each pair.
module operand_feeder #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
`ifdef OPERAND_FEEDER_SUM_EN
    output logic [DATA_W-1:0] out_sum,
    output logic              out_carry,
`endif
    output logic              pending,
    output logic [$clog2(DEPTH):0] pair_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        WAIT_A = 1'b0,
        HAVE_A = 1'b1
    } state_t;

    typedef struct packed {
`ifdef OPERAND_FEEDER_SUM_EN
        logic              carry;
        logic [DATA_W-1:0] sum;
`endif
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } entry_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [PW-1:0]     wr_q, wr_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    entry_t            mem_q [DEPTH];
    entry_t            wr_entry;
    logic              accept;
    logic              push;
    logic              pop;

    // Handshake qualifiers; flush and reset block acceptance, pop is blocked by flush
    assign in_ready = rst_n && !flush && ((state_q == WAIT_A) || (cnt_q < CW'(DEPTH)));
    assign accept   = in_valid && in_ready;
    assign push     = accept && (state_q == HAVE_A);
    assign pop      = out_valid && out_ready && !flush;

    assign out_valid  = (cnt_q != '0);
    assign pending    = (state_q == HAVE_A);
    assign pair_count = cnt_q;
    assign out_a      = mem_q[rd_q].a;
    assign out_b      = mem_q[rd_q].b;
`ifdef OPERAND_FEEDER_SUM_EN
    assign out_sum    = mem_q[rd_q].sum;
    assign out_carry  = mem_q[rd_q].carry;
`endif

    // Entry written on push: the held first operand plus the incoming byte
    always_comb begin
        wr_entry   = '0;
        wr_entry.a = hold_q;
        wr_entry.b = in_data;
`ifdef OPERAND_FEEDER_SUM_EN
        {wr_entry.carry, wr_entry.sum} = (DATA_W+1)'(hold_q) + (DATA_W+1)'(in_data);
`endif
    end

    // Next-state: pairing FSM, pointers and occupancy; flush overrides everything
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = WAIT_A;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
        end else begin
            if (accept) begin
                if (state_q == WAIT_A) begin
                    hold_d  = in_data;
                    state_d = HAVE_A;
                end else begin
                    state_d = WAIT_A;
                    wr_d    = wr_q + PW'(1);
                end
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WAIT_A;
            hold_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pair storage; cleared only by reset, flush leaves contents alone
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_operand_feeder.sv
// Self-checking bench for operand_feeder: queue-based reference model,
// per-cycle compare process, directed literal checks and random traffic.
module tb_operand_feeder;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    bit                clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
`ifdef OPERAND_FEEDER_SUM_EN
    logic [DATA_W-1:0] out_sum;
    logic              out_carry;
`endif
    logic              pending;
    logic [CW-1:0]     pair_count;

    operand_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
`ifdef OPERAND_FEEDER_SUM_EN
        .out_sum    (out_sum),
        .out_carry  (out_carry),
`endif
        .pending    (pending),
        .pair_count (pair_count)
    );

    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: FIFO of pairs plus half-pair holder
    logic [DATA_W-1:0] mq_a[$];
    logic [DATA_W-1:0] mq_b[$];
    bit                m_half;
    logic [DATA_W-1:0] m_held;
    bit                m_acc;
    bit                m_pop;

    function automatic bit m_ready();
        return (rst_n === 1'b1) && (flush === 1'b0) &&
               (!m_half || (mq_a.size() < int'(DEPTH)));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the active edge from the inputs presented in that cycle
    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            mq_a.delete(); mq_b.delete();
            m_half = 0;
            m_held = '0;
        end else if (flush === 1'b1) begin
            mq_a.delete(); mq_b.delete();
            m_half = 0;
        end else begin
            m_acc = (in_valid === 1'b1) && m_ready();
            m_pop = (mq_a.size() != 0) && (out_ready === 1'b1);
            if (m_pop) begin
                void'(mq_a.pop_front());
                void'(mq_b.pop_front());
            end
            if (m_acc) begin
                if (m_half) begin
                    mq_a.push_back(m_held);
                    mq_b.push_back(in_data);
                    m_half = 0;
                end else begin
                    m_held = in_data;
                    m_half = 1;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        logic [DATA_W:0] s;
        chk("in_ready",   32'(in_ready),   32'(m_ready()));
        chk("out_valid",  32'(out_valid),  32'(mq_a.size() != 0));
        chk("pending",    32'(pending),    32'(m_half));
        chk("pair_count", 32'(pair_count), 32'(mq_a.size()));
        if (mq_a.size() != 0) begin
            chk("out_a", 32'(out_a), 32'(mq_a[0]));
            chk("out_b", 32'(out_b), 32'(mq_b[0]));
            s = (DATA_W+1)'(mq_a[0]) + (DATA_W+1)'(mq_b[0]);
`ifdef OPERAND_FEEDER_SUM_EN
            chk("out_sum",   32'(out_sum),   32'(s[DATA_W-1:0]));
            chk("out_carry", 32'(out_carry), 32'(s[DATA_W]));
`else
            if (s[DATA_W] === 1'bx) chk("sum_model", 0, 1);
`endif
        end
    end

    // Offer one byte until accepted, bounded by a cycle budget
    task automatic send(input logic [DATA_W-1:0] b);
        bit ok;
        bit done;
        done     = 0;
        in_valid = 1;
        in_data  = b;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) done = 1;
        end
        if (!done) chk("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_data = '0; flush = 0; out_ready = 0;
        step(2);
        // Reset values
        chk("rst_in_ready",   32'(in_ready),   0);
        chk("rst_out_valid",  32'(out_valid),  0);
        chk("rst_pending",    32'(pending),    0);
        chk("rst_pair_count", 32'(pair_count), 0);
        chk("rst_out_a",      32'(out_a),      0);
        chk("rst_out_b",      32'(out_b),      0);
        rst_n = 1;
        #1 chk("in_ready_after_rst", 32'(in_ready), 1);

        // Single pair 14, 18
        out_ready = 1; in_valid = 1; in_data = 8'd14;
        step(1);
        in_data = 8'd18;
        #1 chk("single_pending", 32'(pending), 1);
        chk("single_not_valid", 32'(out_valid), 0);
        step(1);
        in_valid = 0;
        #1 chk("single_valid", 32'(out_valid), 1);
        chk("single_a", 32'(out_a), 14);
        chk("single_b", 32'(out_b), 18);
`ifdef OPERAND_FEEDER_SUM_EN
        chk("single_sum",   32'(out_sum),   32);
        chk("single_carry", 32'(out_carry), 0);
`endif
        step(1);
        chk("single_popped", 32'(out_valid), 0);

        // Fill with 1..9 under backpressure
        out_ready = 0;
        for (int b = 1; b <= 9; b++) send(DATA_W'(b));
        in_valid = 1; in_data = 8'd10;
        #1 chk("fill_count",   32'(pair_count), 4);
        chk("fill_pending",    32'(pending),    1);
        chk("fill_in_ready",   32'(in_ready),   0);
        chk("fill_head_a",     32'(out_a),      1);
        chk("fill_head_b",     32'(out_b),      2);
        out_ready = 1;
        send(8'd10);
        step(6);

        // Concurrent push/pop at pair_count = 2
        out_ready = 0;
        for (int b = 21; b <= 25; b++) send(DATA_W'(b));
        #1 chk("pp_count_before", 32'(pair_count), 2);
        out_ready = 1; in_valid = 1; in_data = 8'd26;
        step(1);
        in_valid = 0; out_ready = 0;
        #1 chk("pp_count_after", 32'(pair_count), 2);
        chk("pp_head_a", 32'(out_a), 23);
        chk("pp_head_b", 32'(out_b), 24);
        out_ready = 1;
        step(4);

        // Flush mid-pair with three pairs buffered
        out_ready = 0;
        for (int b = 1; b <= 6; b++) send(DATA_W'(b));
        send(8'd5);
        #1 chk("fl_pending_before", 32'(pending), 1);
        chk("fl_count_before", 32'(pair_count), 3);
        flush = 1; in_valid = 1; in_data = 8'd99;
        #1 chk("fl_in_ready", 32'(in_ready), 0);
        step(1);
        flush = 0; in_valid = 0;
        #1 chk("fl_pending", 32'(pending), 0);
        chk("fl_count", 32'(pair_count), 0);
        chk("fl_valid", 32'(out_valid), 0);
        send(8'd7);
        send(8'd8);
        #1 chk("fl_pair_a", 32'(out_a), 7);
        chk("fl_pair_b", 32'(out_b), 8);
        chk("fl_pair_count", 32'(pair_count), 1);
        out_ready = 1;
        step(2);

`ifdef OPERAND_FEEDER_SUM_EN
        // Carry out of the adder
        out_ready = 0;
        send(8'd200);
        send(8'd100);
        #1 chk("carry_sum", 32'(out_sum),   44);
        chk("carry_carry",  32'(out_carry), 1);
        out_ready = 1;
        step(2);
`endif

        // Reset mid-operation with two pairs buffered and a byte held
        out_ready = 0;
        for (int b = 1; b <= 5; b++) send(DATA_W'(b));
        rst_n = 0; in_valid = 1; in_data = 8'd3;
        #1 chk("mr_in_ready_low", 32'(in_ready), 0);
        step(1);
        #1 chk("mr_valid", 32'(out_valid),  0);
        chk("mr_pending",  32'(pending),    0);
        chk("mr_count",    32'(pair_count), 0);
        chk("mr_a",        32'(out_a),      0);
        chk("mr_b",        32'(out_b),      0);
        rst_n = 1; in_valid = 0;
        #1 chk("mr_in_ready_high", 32'(in_ready), 1);

        // Random traffic: slow consumer first, then fast consumer
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DATA_W'($urandom);
            out_ready = (c < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            rst_n     = ($urandom_range(0, 249) != 0);
        end
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
